// File: rtl/spi_slave_if.sv
// SPI slave bundle: the four SPI pin signals plus the host-side
// transmit/receive handshake, seen from the slave or from the driving side.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SCLK;
  logic                  SS;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;

  modport slave (
    input  SCLK, SS, MOSI, tx_data, tx_load,
    output MISO, MISO_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output SCLK, SS, MOSI, tx_data, tx_load,
    input  MISO, MISO_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling SCLK/SS/MOSI on clk_50mhz.
// A one-word holding buffer feeds the transmit shift register at each word
// start; received words are published on rx_data with a one-cycle rx_valid.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input logic        clk_50mhz,
  input logic        reset,
  spi_slave_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;

  logic [1:0]            sclk_sync, ss_sync, mosi_sync, sync_primed;
  logic                  sclk_prev, ss_prev, ss_armed;
  logic                  sclk_s, ss_s, mosi_s;
  logic                  sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [DATA_WIDTH-1:0] tx_shift, hold_buf, rx_shift, rx_data_q;
  logic                  hold_full, rx_valid_q, underrun_q;
  logic [CNT_W-1:0]      bit_cnt;

  logic                  word_start, word_done, ss_release;
  logic                  miso_d, miso_oe_d;

  assign sclk_s    = sclk_sync[1];
  assign ss_s      = ss_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  // A fall only counts once a genuine high SS has been seen since reset,
  // so an SS already held low across reset release does not start a word.
  assign ss_fall   = ss_armed & ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;

  // Synchronizers, edge-detect history and the post-reset SS arming flag.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      sclk_sync   <= 2'b00;
      ss_sync     <= 2'b11;
      mosi_sync   <= 2'b00;
      sclk_prev   <= 1'b0;
      ss_prev     <= 1'b1;
      sync_primed <= 2'b00;
      ss_armed    <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[0], bus.SCLK};
      ss_sync     <= {ss_sync[0], bus.SS};
      mosi_sync   <= {mosi_sync[0], bus.MOSI};
      sclk_prev   <= sclk_s;
      ss_prev     <= ss_s;
      sync_primed <= {sync_primed[0], 1'b1};
      if (sync_primed[1] && ss_s)
        ss_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic, word start/finish strobes and pin outputs.
  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    word_done  = 1'b0;
    ss_release = 1'b0;
    miso_d     = 1'b0;
    miso_oe_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        miso_oe_d = 1'b1;
        miso_d    = tx_shift[DATA_WIDTH-1];
        if (ss_rise) begin
          state_d    = IDLE;
          ss_release = 1'b1;
        end else if (sclk_rise && bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
          word_done  = 1'b1;
          word_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding buffer, shift registers, bit counter and status pulses.
  // The falling edge that follows a word's last rising edge must not shift:
  // the next word's MSB was just loaded, so shifting is skipped at bit 0.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      tx_shift   <= '0;
      hold_buf   <= '0;
      hold_full  <= 1'b0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      bit_cnt    <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= word_done;
      underrun_q <= word_start & ~hold_full;

      if (bus.tx_load && !hold_full) begin
        hold_buf  <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (word_start) begin
        if (hold_full) begin
          tx_shift  <= hold_buf;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= '0;
        end
      end else if (ss_release) begin
        tx_shift <= '0;
      end else if (state_q == SHIFT && sclk_fall && bit_cnt != '0) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (state_q != SHIFT || ss_release)
        rx_shift <= '0;
      else if (sclk_rise)
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};

      if (word_start || ss_release)
        bit_cnt <= '0;
      else if (state_q == SHIFT && sclk_rise)
        bit_cnt <= bit_cnt + 1'b1;

      if (word_done)
        rx_data_q <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
    end
  end

  assign bus.MISO        = miso_d;
  assign bus.MISO_oe     = miso_oe_d;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 SPI master at SCLK = clk/8 plus
// host-side loads, with hand-computed expected words and event counts.
module tb_spi_slave;
  localparam int DW = 8;

  logic clk_50mhz = 1'b0;
  logic reset;

  int checks       = 0;
  int errors       = 0;
  int valid_cnt    = 0;
  int underrun_cnt = 0;

  spi_slave_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave #(.DATA_WIDTH(DW)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .bus       (bus)
  );

  // 50 MHz system clock.
  always #10 clk_50mhz = ~clk_50mhz;

  // Count rx_valid and tx_underrun pulses, sampled mid-cycle.
  always @(negedge clk_50mhz) begin
    if (bus.rx_valid === 1'b1) valid_cnt++;
    if (bus.tx_underrun === 1'b1) underrun_cnt++;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic load_tx(input logic [DW-1:0] d);
    @(negedge clk_50mhz);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk_50mhz);
    bus.tx_load = 1'b0;
  endtask

  task automatic ss_select();
    @(negedge clk_50mhz);
    bus.SS = 1'b0;
    wait_cycles(5);
  endtask

  task automatic ss_deselect();
    wait_cycles(4);
    bus.SS = 1'b1;
    wait_cycles(6);
  endtask

  // Mode-0 master: MOSI set during SCLK low, MISO sampled at the rise.
  task automatic spi_word(input logic [DW-1:0] mosi_word, input int nbits,
                          output logic [DW-1:0] miso_word);
    logic seen;
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = mosi_word[DW-1-i];
      wait_cycles(4);
      bus.SCLK  = 1'b1;
      miso_word = {miso_word[DW-2:0], bus.MISO};
      seen      = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_50mhz);
        if (bus.rx_valid === 1'b1) seen = 1'b1;
      end
      bus.SCLK = 1'b0;
      if (i == DW - 1) check_output("rx_valid_latency", {15'b0, seen}, 16'h0001);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    logic [DW-1:0] m;
    int v0, u0;

    reset       = 1'b0;
    bus.SCLK    = 1'b0;
    bus.SS      = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    wait_cycles(4);
    check_output("rst_miso", {15'b0, bus.MISO}, 16'h0000);
    check_output("rst_miso_oe", {15'b0, bus.MISO_oe}, 16'h0000);
    check_output("rst_tx_ready", {15'b0, bus.tx_ready}, 16'h0001);
    check_output("rst_rx_valid", {15'b0, bus.rx_valid}, 16'h0000);
    check_output("rst_underrun", {15'b0, bus.tx_underrun}, 16'h0000);
    check_output("rst_rx_data", {8'b0, bus.rx_data}, 16'h0000);
    reset = 1'b1;
    wait_cycles(6);

    $display("[TB] single word, tx 0xA5 rx 0x3C");
    load_tx(8'hA5);
    check_output("load_tx_ready_low", {15'b0, bus.tx_ready}, 16'h0000);
    v0 = valid_cnt;
    u0 = underrun_cnt;
    ss_select();
    check_output("start_tx_ready", {15'b0, bus.tx_ready}, 16'h0001);
    check_output("start_miso_oe", {15'b0, bus.MISO_oe}, 16'h0001);
    check_output("start_no_underrun", 16'(underrun_cnt - u0), 16'h0000);
    spi_word(8'h3C, 8, m);
    check_output("w1_miso_word", {8'b0, m}, 16'h00A5);
    check_output("w1_rx_data", {8'b0, bus.rx_data}, 16'h003C);
    ss_deselect();
    check_output("w1_valid_count", 16'(valid_cnt - v0), 16'h0001);
    check_output("idle_miso_oe", {15'b0, bus.MISO_oe}, 16'h0000);
    check_output("idle_miso", {15'b0, bus.MISO}, 16'h0000);

    $display("[TB] back-to-back words");
    load_tx(8'h12);
    v0 = valid_cnt;
    ss_select();
    load_tx(8'h34);
    spi_word(8'hF0, 8, m);
    check_output("b2b_miso_0", {8'b0, m}, 16'h0012);
    check_output("b2b_rx_0", {8'b0, bus.rx_data}, 16'h00F0);
    spi_word(8'h0F, 8, m);
    check_output("b2b_miso_1", {8'b0, m}, 16'h0034);
    check_output("b2b_rx_1", {8'b0, bus.rx_data}, 16'h000F);
    ss_deselect();
    check_output("b2b_valid_count", 16'(valid_cnt - v0), 16'h0002);

    $display("[TB] underrun");
    u0 = underrun_cnt;
    ss_select();
    check_output("underrun_pulse", 16'(underrun_cnt - u0), 16'h0001);
    spi_word(8'h5A, 8, m);
    check_output("underrun_miso", {8'b0, m}, 16'h0000);
    check_output("underrun_rx", {8'b0, bus.rx_data}, 16'h005A);
    ss_deselect();

    $display("[TB] aborted partial word");
    v0 = valid_cnt;
    ss_select();
    spi_word(8'hFF, 5, m);
    ss_deselect();
    check_output("abort_no_valid", 16'(valid_cnt - v0), 16'h0000);
    check_output("abort_rx_kept", {8'b0, bus.rx_data}, 16'h005A);
    ss_select();
    spi_word(8'hC3, 8, m);
    check_output("after_abort_rx", {8'b0, bus.rx_data}, 16'h00C3);
    ss_deselect();

    $display("[TB] load while buffer full");
    load_tx(8'h11);
    load_tx(8'h77);
    check_output("full_tx_ready", {15'b0, bus.tx_ready}, 16'h0000);
    ss_select();
    spi_word(8'h00, 8, m);
    check_output("full_miso", {8'b0, m}, 16'h0011);
    ss_deselect();
    check_output("full_tx_ready_after", {15'b0, bus.tx_ready}, 16'h0001);
    ss_select();
    spi_word(8'h81, 8, m);
    check_output("ignored_load_miso", {8'b0, m}, 16'h0000);
    check_output("ignored_load_rx", {8'b0, bus.rx_data}, 16'h0081);
    ss_deselect();

    $display("[TB] reset mid-word");
    v0 = valid_cnt;
    ss_select();
    load_tx(8'h99);
    spi_word(8'hE7, 4, m);
    @(negedge clk_50mhz);
    reset = 1'b0;
    #1;
    check_output("midrst_miso_oe", {15'b0, bus.MISO_oe}, 16'h0000);
    check_output("midrst_miso", {15'b0, bus.MISO}, 16'h0000);
    check_output("midrst_tx_ready", {15'b0, bus.tx_ready}, 16'h0001);
    check_output("midrst_rx_data", {8'b0, bus.rx_data}, 16'h0000);
    check_output("midrst_rx_valid", {15'b0, bus.rx_valid}, 16'h0000);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(10);
    check_output("postrst_stays_idle", {15'b0, bus.MISO_oe}, 16'h0000);
    check_output("midrst_no_valid", 16'(valid_cnt - v0), 16'h0000);
    bus.SS = 1'b1;
    wait_cycles(6);
    load_tx(8'h5C);
    ss_select();
    spi_word(8'h96, 8, m);
    check_output("postrst_miso", {8'b0, m}, 16'h005C);
    check_output("postrst_rx", {8'b0, bus.rx_data}, 16'h0096);
    ss_deselect();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no completion expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, bits per SPI word.
REQ-002 Port: clk_50mhz  input  1  system clock, 50 MHz; the block's only clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: SCLK  input  1  SPI serial clock from master; asynchronous to clk_50mhz.
REQ-005 Port: SS  input  1  slave select from master, active-low; asynchronous.
REQ-006 Port: MOSI  input  1  serial data from master; asynchronous.
REQ-007 Port: MISO  output  1  serial data to master.
REQ-008 Port: MISO_oe  output  1  MISO output enable; the top level drives MISO onto the pin only while this is 1.
REQ-009 Port: tx_data  input  DATA_WIDTH  next word to transmit.
REQ-010 Port: tx_load  input  1  write strobe for tx_data.
REQ-011 Port: tx_ready  output  1  transmit holding buffer empty.
REQ-012 Port: rx_data  output  DATA_WIDTH  last complete received word.
REQ-013 Port: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 Port: tx_underrun  output  1  one-cycle pulse when a word starts with the holding buffer empty.

Function
REQ-015 SPI mode 0 (CPOL=0, CPHA=0), MSB first: MOSI sampled on SCLK rising edges; MISO changes on SCLK falling edges.
REQ-016 SCLK, SS and MOSI each pass through a 2-flop synchronizer on clk_50mhz before use.
- SCLK edges and SS edges are detected from the synchronized signals.
REQ-017 Supported SCLK: period >= 8 clk_50mhz cycles, high and low phases >= 4 cycles each; SS fall to first SCLK rise >= 4 cycles.
REQ-018 FSM states:
- IDLE: SS high; MISO_oe=0; MISO=0.
- SHIFT: SS low; MISO_oe=1.
REQ-019 IDLE->SHIFT on synchronized SS fall; SHIFT->IDLE on synchronized SS rise, from any bit position.
REQ-020 Word start (SS fall, or word completion while SS stays low):
- If the holding buffer is full: tx shift register loads the buffer; buffer becomes empty; tx_ready=1.
- Otherwise: tx shift register loads all zeros and tx_underrun pulses one cycle.
- In both cases bit counter=0 and MISO presents the tx shift register MSB.
REQ-021 On each synchronized SCLK rise in SHIFT: synchronized MOSI shifts into the rx shift register LSB; bit counter increments.
REQ-022 On each synchronized SCLK fall in SHIFT: tx shift register shifts left; MISO = new MSB.
REQ-023 Word completion = the DATA_WIDTH-th rising edge. At completion:
- rx_data <= assembled word; rx_valid=1 for exactly one cycle on the following clock.
- The word-start action (REQ-020) occurs on the same completion cycle, so back-to-back words are supported without releasing SS.
REQ-024 Latency: rx_valid asserts no later than 4 clk_50mhz cycles after the final SCLK rising edge at the pin.
REQ-025 Tx handshake:
- tx_load while tx_ready=1: captures tx_data; tx_ready=0 on the next cycle.
- tx_load while tx_ready=0: ignored; buffer unchanged.
REQ-026 Simultaneous tx_load and word start with the buffer empty: the word start sees the buffer empty (zeros sent, tx_underrun pulses); the load is accepted and held for the next word.
REQ-027 SS rise before word completion:
- Partial word discarded; no rx_valid; rx_data unchanged.
- Bit counter cleared.
- The holding buffer keeps its contents; a word already moved into the shift register is lost.
REQ-028 SCLK edges while in IDLE are ignored.
REQ-029 rx_data holds its value until the next completed word.

Reset
REQ-030 While reset=0 (asynchronous assertion):
- State=IDLE; MISO=0; MISO_oe=0; tx_ready=1; rx_valid=0; tx_underrun=0; rx_data=0.
- Holding buffer empty; shift registers, bit counter and synchronizers all cleared (synchronizers cleared to 1 for SS, 0 for SCLK and MOSI).
REQ-031 Reset asserted mid-word aborts the transfer with no rx_valid; after release the block waits for a fresh SS fall, even if SS is already low.

Verification
REQ-032 Load 0xA5 via tx_load; master sends 0x3C at SCLK = clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready=1 after SS fall.
REQ-033 Two back-to-back words, SS held low: tx 0x12 then 0x34 loaded before the 2nd word start; master sends 0xF0, 0x0F -> MISO words 0x12, 0x34; two rx_valid pulses with 0xF0 then 0x0F.
REQ-034 No tx_load before SS fall -> MISO all zeros; one tx_underrun pulse; rx still correct.
REQ-035 SS released after 5 SCLK rises -> no rx_valid; rx_data unchanged. Next full word is received correctly from bit 0.
REQ-036 tx_load with tx_ready=0 (0x77 after 0x11 is pending) -> 0x11 transmitted; 0x77 never appears on MISO.
REQ-037 reset pulsed low at bit 4 -> all outputs at reset values immediately; no rx_valid. A subsequent transfer after a fresh SS fall succeeds.
